// File: rtl/out_scan_mux_if.sv
// Handshake/data bundle between a packed multi-channel source and the BCD stage.
// The slave modport is the mux itself; the master side drives channels, select and ready.
interface out_scan_mux_if #(
  parameter int BITS = 16,
  parameter int CH   = 4
);
  localparam int CW = $clog2(CH);

  logic [CH*BITS-1:0] din;
  logic [CW-1:0]      sel;
  logic               mode;
  logic               out_ready;
  logic               out_valid;
  logic               out_sign;
  logic [BITS-1:0]    to_bcd;
  logic [CW-1:0]      out_ch;

  modport master (
    output din, sel, mode, out_ready,
    input  out_valid, out_sign, to_bcd, out_ch
  );

  modport slave (
    input  din, sel, mode, out_ready,
    output out_valid, out_sign, to_bcd, out_ch
  );
endinterface

// File: rtl/out_scan_mux.sv
// Captures one channel of a packed bus (manual select or timed auto-scan) and presents it
// over valid/ready. Define OUT_SCAN_SIGNED_EN to output sign/magnitude instead of raw unsigned.
module out_scan_mux #(
  parameter int BITS  = 16,
  parameter int CH    = 4,
  parameter int DWELL = 50000000
) (
  input logic           clk,
  input logic           rst_n,
  out_scan_mux_if.slave bus
);
  localparam int CW = $clog2(CH);
  localparam int NW = $clog2(DWELL);

  typedef enum logic [1:0] {IDLE, CAPTURE, PRESENT} state_t;

  state_t          state;
  logic [BITS-1:0] raw;
  logic [NW-1:0]   count;
  logic [CW-1:0]   scan;
  logic            pending;
  logic            first;
  logic            mode_q;

  logic [CW-1:0]   sel_ch;
  logic [CW-1:0]   idx;
  logic [BITS-1:0] sample;
  logic [BITS-1:0] mag;
  logic            sign;
  logic            scan_start;
  logic            dwell_hit;
  logic            manual_trig;
  logic            trig;

  always_comb begin
    sel_ch = bus.sel;
    if (int'(bus.sel) >= CH) sel_ch = CW'(CH - 1);
    idx    = bus.mode ? scan : sel_ch;
    sample = bus.din[idx*BITS +: BITS];
`ifdef OUT_SCAN_SIGNED_EN
    sign = sample[BITS-1];
    mag  = sign ? -sample : sample;
`else
    sign = 1'b0;
    mag  = sample;
`endif
    // Entering auto mode restarts the dwell, so no dwell trigger on that cycle.
    scan_start  = bus.mode && !mode_q;
    dwell_hit   = bus.mode && !scan_start && (count == NW'(DWELL - 1));
    manual_trig = !bus.mode && ((sel_ch != bus.out_ch) || (sample != raw));
    trig        = first || dwell_hit || manual_trig;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.out_valid <= 1'b0;
      bus.out_sign  <= 1'b0;
      bus.to_bcd    <= '0;
      bus.out_ch    <= '0;
      raw           <= '0;
      count         <= '0;
      scan          <= '0;
      pending       <= 1'b0;
      first         <= 1'b1;
      mode_q        <= bus.mode;
    end else begin
      mode_q <= bus.mode;
      if (scan_start) begin
        count <= '0;
        scan  <= bus.out_ch;
      end else if (bus.mode) begin
        if (dwell_hit) begin
          count <= '0;
          scan  <= (scan == CW'(CH - 1)) ? '0 : scan + CW'(1);
        end else begin
          count <= count + NW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (trig || pending) begin
            state   <= CAPTURE;
            pending <= 1'b0;
          end
        end
        CAPTURE: begin
          // The capture itself satisfies manual and first-flag requests; only a
          // dwell expiry landing on this cycle must be remembered.
          raw          <= sample;
          bus.out_ch   <= idx;
          bus.out_sign <= sign;
          bus.to_bcd   <= mag;
          first        <= 1'b0;
          state        <= PRESENT;
          if (dwell_hit) pending <= 1'b1;
        end
        PRESENT: begin
          if (trig) pending <= 1'b1;
          if (!bus.out_valid) begin
            bus.out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_out_scan_mux.sv
// Self-checking bench for out_scan_mux: directed vector table, multi-cycle sequences
// and randomized manual-mode traffic against a transaction-level reference model.
module tb_out_scan_mux;
  localparam int BITS  = 16;
  localparam int CH    = 4;
  localparam int DWELL = 8;
`ifdef OUT_SCAN_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [BITS-1:0] ch_val [CH];

  out_scan_mux_if #(.BITS(BITS), .CH(CH)) bus ();

  out_scan_mux #(.BITS(BITS), .CH(CH), .DWELL(DWELL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              sel;
    logic [BITS-1:0] val;
    logic            sgn;
    logic [BITS-1:0] mag;
  } vec_t;

  vec_t vecs [7];

  // Reference conversion from the arithmetic definition of a two's-complement value.
  function automatic logic exp_sign(input logic [BITS-1:0] v);
    return SIGNED && (longint'(v) >= (longint'(1) << (BITS - 1)));
  endfunction

  function automatic logic [BITS-1:0] exp_mag(input logic [BITS-1:0] v);
    if (exp_sign(v)) return BITS'((longint'(1) << BITS) - longint'(v));
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic mode, input logic ready);
    for (int k = 0; k < CH; k++) bus.din[k*BITS +: BITS] = ch_val[k];
    bus.sel       = 2'(sel);
    bus.mode      = mode;
    bus.out_ready = ready;
  endtask

  task automatic waitValid(input string name, input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (bus.out_valid) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s no valid within %0d cycles", name, limit);
    end
  endtask

  task automatic checkSample(input string name, input int ch, input logic [BITS-1:0] v);
    checkOutput({name, " ch"},   32'(bus.out_ch),   32'(ch));
    checkOutput({name, " sign"}, 32'(bus.out_sign), 32'(exp_sign(v)));
    checkOutput({name, " bcd"},  32'(bus.to_bcd),   32'(exp_mag(v)));
  endtask

  task automatic checkZeroOutputs(input string name);
    checkOutput({name, " valid"}, 32'(bus.out_valid), 0);
    checkOutput({name, " ch"},    32'(bus.out_ch),    0);
    checkOutput({name, " sign"},  32'(bus.out_sign),  0);
    checkOutput({name, " bcd"},   32'(bus.to_bcd),    0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit found;
    int seen;
    int s;
    int cyc_now;
    logic r;
    logic hold;
    logic [31:0] held;
    int q_cyc [$];
    int q_ch [$];
    logic [BITS-1:0] q_bcd [$];
    logic prev_valid;

    vecs[0] = '{2, 16'hFFF6, 1'b1, 16'h000A};
    vecs[1] = '{1, 16'h0007, 1'b0, 16'h0007};
    vecs[2] = '{0, 16'h8000, 1'b1, 16'h8000};
    vecs[3] = '{3, 16'h7FFF, 1'b0, 16'h7FFF};
    vecs[4] = '{3, 16'h0001, 1'b0, 16'h0001};
    vecs[5] = '{0, 16'hFFFF, 1'b1, 16'h0001};
    vecs[6] = '{2, 16'h0000, 1'b0, 16'h0000};

    // Reset state, then first-capture latency with ready high.
    for (int k = 0; k < CH; k++) ch_val[k] = 16'h0000;
    ch_val[2] = 16'hFFF6;
    applyStimulus(2, 1'b0, 1'b1);
    doReset();
    checkZeroOutputs("reset");
    @(posedge clk); #1;
    checkOutput("latency edge n valid", 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    checkOutput("latency edge n+1 valid", 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    checkOutput("latency edge n+2 valid", 32'(bus.out_valid), 1);
    checkSample("first capture", 2, 16'hFFF6);

    // Back-pressure: outputs hold while a new request is merged into pending.
    @(negedge clk);
    applyStimulus(2, 1'b0, 1'b0);
    doReset();
    waitValid("hold present", 10, found);
    @(negedge clk);
    ch_val[1] = 16'h0007;
    applyStimulus(1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold valid", 32'(bus.out_valid), 1);
      checkSample("hold data", 2, 16'hFFF6);
    end
    bus.out_ready = 1'b1;
    waitValid("pending sample", 20, found);
    if (found) checkSample("pending sample", 1, 16'h0007);
    @(negedge clk);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    checkOutput("no extra sample", 32'(seen), 0);

    // Directed vector table in manual mode.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ch_val[vecs[i].sel] = vecs[i].val;
      applyStimulus(vecs[i].sel, 1'b0, 1'b1);
      waitValid($sformatf("vec%0d", i), 20, found);
      if (found) begin
        checkOutput($sformatf("vec%0d ch", i), 32'(bus.out_ch), 32'(vecs[i].sel));
        checkOutput($sformatf("vec%0d sign", i), 32'(bus.out_sign),
                    32'(SIGNED ? vecs[i].sgn : 1'b0));
        checkOutput($sformatf("vec%0d bcd", i), 32'(bus.to_bcd),
                    32'(SIGNED ? vecs[i].mag : vecs[i].val));
      end
      @(negedge clk);
      checkOutput($sformatf("vec%0d consumed", i), 32'(bus.out_valid), 0);
    end

    // Reset while presenting, then the forced capture of an all-zero channel.
    @(negedge clk);
    ch_val[1] = 16'h1234;
    applyStimulus(1, 1'b0, 1'b0);
    waitValid("pre-reset present", 20, found);
    rst_n = 1'b0;
    for (int k = 0; k < CH; k++) ch_val[k] = 16'h0000;
    applyStimulus(0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkZeroOutputs("reset in present");
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    waitValid("forced capture", 10, found);
    if (found) checkSample("forced capture", 0, 16'h0000);
    @(negedge clk);

    // Randomized manual traffic; after settling the last capture must match din[sel].
    for (int it = 0; it < 25; it++) begin
      @(negedge clk);
      ch_val[$urandom_range(0, CH - 1)] = BITS'($urandom);
      s = $urandom_range(0, CH - 1);
      applyStimulus(s, 1'b0, 1'b0);
      hold = 1'b0;
      held = '0;
      for (int cyc = 0; cyc < 40; cyc++) begin
        r = (cyc >= 15) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.out_ready = r;
        if (bus.out_valid) begin
          if (hold) checkOutput("rand hold stable", {13'd0, bus.out_ch, bus.out_sign, bus.to_bcd}, held);
          hold = !r;
          held = {13'd0, bus.out_ch, bus.out_sign, bus.to_bcd};
        end else begin
          hold = 1'b0;
        end
        @(negedge clk);
      end
      checkOutput("rand settled valid", 32'(bus.out_valid), 0);
      checkSample($sformatf("rand%0d", it), s, ch_val[s]);
    end

    // Manual to auto: scan resumes from the channel last presented.
    @(negedge clk);
    ch_val[2] = 16'h0123;
    applyStimulus(2, 1'b0, 1'b1);
    waitValid("pre-auto", 20, found);
    @(negedge clk);
    ch_val[3] = 16'hFF00;
    applyStimulus(2, 1'b1, 1'b1);
    waitValid("auto resume", 20, found);
    if (found) checkSample("auto resume", 3, 16'hFF00);

    // Auto scan from reset: channel order, wrap and dwell spacing.
    @(negedge clk);
    for (int k = 0; k < CH; k++) ch_val[k] = BITS'(k + 1);
    applyStimulus(0, 1'b1, 1'b1);
    doReset();
    prev_valid = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      cyc_now = cyc;
      if (bus.out_valid && !prev_valid) begin
        q_cyc.push_back(cyc_now);
        q_ch.push_back(int'(bus.out_ch));
        q_bcd.push_back(bus.to_bcd);
      end
      prev_valid = bus.out_valid;
    end
    if (q_ch.size() < 5) begin
      checks++;
      errors++;
      $display("[TB] FAIL auto samples got=%0d required=5", q_ch.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checkOutput($sformatf("auto%0d ch", i), 32'(q_ch[i]), 32'(i % CH));
        checkOutput($sformatf("auto%0d bcd", i), 32'(q_bcd[i]), 32'((i % CH) + 1));
        if (i >= 2)
          checkOutput($sformatf("auto%0d interval", i), 32'(q_cyc[i] - q_cyc[i-1]), DWELL);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/out_scan_mux.md
OUT_SCAN_MUX -- requirements
Module: out_scan_mux

Interface
REQ-001 Parameters SHALL be: BITS, default 16, channel width; CH, default 4 (legal 2..8), channel count; DWELL, default 50000000, auto-scan cycles per channel (>=2).
REQ-002 Ports SHALL be as follows.
- CLK  in  1  sole clock, rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- DIN  in  CH*BITS  packed channels; channel k at bits [k*BITS +: BITS].
- SEL  in  clog2(CH)  manual channel select; values >= CH select channel CH-1.
- MODE  in  1  0 = manual, 1 = auto-scan.
- OUT_READY  in  1  downstream BCD converter accepts.
- OUT_VALID  out  1  presented sample valid.
- OUT_SIGN  out  1  sign of presented sample.
- TO_BCD  out  BITS  magnitude of presented sample.
- OUT_CH  out  clog2(CH)  channel index of presented sample.

Function
REQ-003 The FSM SHALL have states IDLE, CAPTURE and PRESENT.
REQ-004 IDLE: OUT_VALID=0; on a trigger or a set pending flag, the FSM SHALL go to CAPTURE next cycle and clear pending.
REQ-005 CAPTURE (one cycle): the block SHALL register raw=DIN[idx], OUT_CH=idx, OUT_SIGN and TO_BCD; next state PRESENT.
- idx = SEL in manual mode, scan index in auto mode.
REQ-006 PRESENT: OUT_VALID=1, with OUT_SIGN/TO_BCD/OUT_CH stable; on OUT_READY=1 the FSM SHALL return to IDLE next cycle.
REQ-007 Latency: a trigger sampled in IDLE at edge n SHALL give OUT_VALID=1 with new data after edge n+2.
REQ-008 Manual trigger SHALL occur when SEL != OUT_CH, when DIN[SEL] != raw, or when the first flag is set.
REQ-009 Auto trigger SHALL occur when the dwell counter reaches DWELL-1. At that point:
- counter SHALL go to 0;
- scan index SHALL increment, wrapping CH-1 -> 0.
REQ-010 Triggers arising in CAPTURE or PRESENT SHALL set a one-deep pending flag; further triggers SHALL merge into it and SHALL NOT be lost.
REQ-011 Dwell counter and scan index SHALL advance regardless of FSM state while MODE=1, and SHALL hold while MODE=0.
REQ-012 On a MODE 0->1 transition, the counter SHALL restart at 0 and the scan index SHALL load OUT_CH.
REQ-013 Sign/magnitude conversion (with macro) SHALL be OUT_SIGN=raw[BITS-1] and TO_BCD = two's-complement negation of raw when negative, raw otherwise.
- Most-negative input SHALL give OUT_SIGN=1, TO_BCD=2^(BITS-1).

Reset
REQ-014 When RST_N=0 at a rising edge, the block SHALL set:
- state IDLE;
- OUT_VALID, OUT_SIGN, TO_BCD, OUT_CH = 0;
- raw, counter, scan index = 0;
- pending = 0, first flag = 1.
REQ-015 Reset SHALL take effect from any state, including PRESENT; OUT_VALID SHALL be 0 after that edge, with no handshake required.
REQ-016 After reset release, the first flag SHALL force one capture in either mode; the flag SHALL clear in CAPTURE.

Configuration
REQ-017 Macro OUT_SCAN_SIGNED_EN SHALL control sign handling.
- Defined: REQ-013 conversion applies.
- Undefined: OUT_SIGN SHALL be constant 0, TO_BCD SHALL equal raw unsigned, and no negation logic SHALL be synthesised.

Verification (BITS=16, CH=4, DWELL=8, macro defined unless stated)
REQ-018 Reset, MODE=0, SEL=2, DIN ch2=0xFFF6, OUT_READY=1 -> OUT_VALID=1, OUT_SIGN=1, TO_BCD=0x000A, OUT_CH=2, two edges after first IDLE trigger.
REQ-019 Hold OUT_READY=0 5 cycles in PRESENT; switch SEL to 1 (ch1=0x0007) -> outputs unchanged for 5 cycles; after handshake, one further sample: OUT_CH=1, OUT_SIGN=0, TO_BCD=0x0007.
REQ-020 MODE=1, OUT_READY=1, DIN channels 1,2,3,4 -> OUT_CH sequence 0,1,2,3,0 at 8-cycle intervals, wrap checked.
REQ-021 DIN ch0=0x8000, SEL=0 -> OUT_SIGN=1, TO_BCD=0x8000.
REQ-022 RST_N=0 for one edge during PRESENT -> OUT_VALID=0 and outputs 0 after that edge; after release, forced capture of DIN[SEL] even if equal to 0.
REQ-023 Macro undefined, DIN ch2=0xFFF6, SEL=2 -> OUT_SIGN=0, TO_BCD=0xFFF6.
